mem_port_arb: RTL and testbench
===============================

# mem_port_arb

N-port round-robin arbiter that shares one burst-capable main-memory port between cache/DMA masters. It replaces the fixed two-port icache/dcache arbitration in the `REAL_CACHE` build and sits between the cache memory-side interfaces and `memory`. It locks the port for the length of each write burst. It tracks outstanding read bursts in a return-order FIFO so that each `rd_valid` beat is steered to the port that issued the read.

## Interface
- NPORTS, 3: number of requesters; port 0 wins the first arbitration after reset.
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 32: memory beat width.
- BURSTLEN_WIDTH, 3: burst length field width; beats = burst_len + 1.
- MAX_OUTSTANDING, 4: depth of the read-return FIFO; power of 2.

Ports:
- clock  in  1  single clock; all state on posedge.
- reset  in  1  synchronous, active-high reset.
- c_addr  in  NPORTS*ADDR_WIDTH  per-port address; port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- c_burst_len  in  NPORTS*BURSTLEN_WIDTH  per-port burst length.
- c_data_in  in  NPORTS*DATA_WIDTH  per-port write data.
- c_rd  in  NPORTS  per-port read request.
- c_wr  in  NPORTS  per-port write beat valid.
- c_waitrequest  out  NPORTS  per-port stall; a command or beat is accepted when request && !waitrequest.
- c_data_out  out  DATA_WIDTH  read data, broadcast to all ports.
- c_rd_valid  out  NPORTS  per-port read-beat valid.
- mm_addr, mm_burst_len, mm_data_out, mm_rd, mm_wr  out  memory command and write-data fields, widths as above.
- mm_data_in  in  DATA_WIDTH  memory read data.
- mm_waitrequest  in  1  memory stall.
- mm_rd_valid  in  1  memory read beat.
- stray_rd_valid  out  1  one-cycle pulse when mm_rd_valid arrives with the FIFO empty.

## Operation
- States:
  - IDLE: arbitrate.
  - WBURST: locked to `owner` for the remaining write beats.
- Arbitration in IDLE:
  - Eligible port: c_rd[i] or c_wr[i] set.
  - A read-only requester is ineligible while the FIFO is full.
  - The winner is the first eligible port at or after `rr_ptr`, searching with wrap-around.
- Command passthrough: the winner's addr, burst_len, data, rd and wr drive mm_*. With no winner, mm_rd = mm_wr = 0 and the other mm_* fields are don't-care.
- Acceptance: c_waitrequest[winner] = mm_waitrequest. Every non-winning port sees waitrequest = 1.
- A port asserting both rd and wr is treated as a write; its rd is ignored that cycle.
- Read accepted (mm_rd && !mm_waitrequest):
  - Push {port, burst_len} into the FIFO.
  - rr_ptr <= winner + 1 (mod NPORTS).
  - Remain in IDLE.
- Write first beat accepted:
  - burst_len = 0: single beat; update rr_ptr and stay in IDLE.
  - Otherwise: owner <= winner, wbeats <= burst_len, go to WBURST.
- WBURST:
  - Only the owner is routed to mm_*; mm_rd is forced to 0.
  - Each accepted beat decrements wbeats.
  - On the beat accepted with wbeats = 1: rr_ptr <= owner + 1, return to IDLE.
  - While the owner deasserts wr, the burst simply stalls; there is no timeout.
- Read return:
  - c_data_out = mm_data_in.
  - c_rd_valid[head.port] = mm_rd_valid while the FIFO is non-empty.
  - A beat counter, starting at 0, increments per beat. When it equals head.burst_len, pop the FIFO and clear the counter.
- Writes may be granted while reads are outstanding; the memory is responsible for ordering.
- FIFO push and pop in the same cycle are both performed and the count is unchanged.
- Full rule: a push is never made while the FIFO is full, including a cycle in which a pop also occurs. This keeps mm_rd_valid out of the grant path.
- stray_rd_valid: pulses when mm_rd_valid = 1 with the FIFO empty. The beat is dropped and no c_rd_valid is asserted.

## Timing
- Zero-cycle combinational grant and passthrough: request to mm_* in the same cycle.
- Read data: c_rd_valid and c_data_out are combinational from mm_rd_valid and mm_data_in, adding 0 cycles.
- Reset values:
  - State IDLE, rr_ptr 0, FIFO empty, beat counter 0, wbeats 0.
  - mm_rd = mm_wr = 0, c_waitrequest all 1, c_rd_valid all 0, stray_rd_valid 0.
- Reset asserted mid-burst or mid-return: all state is cleared on that edge. Return beats still in flight afterwards raise stray_rd_valid and are not routed.
- Grant changes only in IDLE. A waited-on request (mm_waitrequest = 1) keeps its grant because rr_ptr does not move.

## Test plan
- Contention: ports 0, 1 and 2 each issue a 1-beat read every cycle, mm_waitrequest = 0 -> grants in order 0, 1, 2, 0, …; no port starves; the FIFO fills to 4 and further reads stall until returns pop it.
- Write lock: port 1 writes burst_len = 3 while port 0 and port 2 request reads -> 4 consecutive mm_wr beats from port 1, with port 1 wr held low for 2 cycles mid-burst; then port 2 is granted, then port 0.
- Return routing: port 2 reads burst_len = 3, then port 0 reads burst_len = 1; memory returns 6 beats -> c_rd_valid[2] for 4 beats, then c_rd_valid[0] for 2 beats.
- Backpressure: mm_waitrequest = 1 for 5 cycles while port 1 reads -> port 1 waitrequest is held and the grant is unchanged; FIFO push occurs only on the accept cycle.
- Reset mid-operation: reset during a write burst with 2 reads outstanding -> next cycle is IDLE with FIFO empty; 3 late mm_rd_valid beats give 3 stray_rd_valid pulses and no c_rd_valid.

Source files
------------

// File: rtl/mem_port_arb_if.sv
// Bundles the cache-side request/return signals and the shared main-memory port
// handled by mem_port_arb.
interface mem_port_arb_if #(
  parameter int NPORTS         = 3,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BURSTLEN_WIDTH = 3
);
  logic [NPORTS*ADDR_WIDTH-1:0]     c_addr;
  logic [NPORTS*BURSTLEN_WIDTH-1:0] c_burst_len;
  logic [NPORTS*DATA_WIDTH-1:0]     c_data_in;
  logic [NPORTS-1:0]                c_rd;
  logic [NPORTS-1:0]                c_wr;
  logic [NPORTS-1:0]                c_waitrequest;
  logic [DATA_WIDTH-1:0]            c_data_out;
  logic [NPORTS-1:0]                c_rd_valid;

  logic [ADDR_WIDTH-1:0]            mm_addr;
  logic [BURSTLEN_WIDTH-1:0]        mm_burst_len;
  logic [DATA_WIDTH-1:0]            mm_data_out;
  logic                             mm_rd;
  logic                             mm_wr;
  logic [DATA_WIDTH-1:0]            mm_data_in;
  logic                             mm_waitrequest;
  logic                             mm_rd_valid;

  logic                             stray_rd_valid;

  // Arbiter view: slave to the caches, master toward memory.
  modport slave (
    input  c_addr, c_burst_len, c_data_in, c_rd, c_wr,
    output c_waitrequest, c_data_out, c_rd_valid,
    output mm_addr, mm_burst_len, mm_data_out, mm_rd, mm_wr,
    input  mm_data_in, mm_waitrequest, mm_rd_valid,
    output stray_rd_valid
  );

  modport master (
    output c_addr, c_burst_len, c_data_in, c_rd, c_wr,
    input  c_waitrequest, c_data_out, c_rd_valid,
    input  mm_addr, mm_burst_len, mm_data_out, mm_rd, mm_wr,
    output mm_data_in, mm_waitrequest, mm_rd_valid,
    input  stray_rd_valid
  );
endinterface

// File: rtl/mem_port_arb.sv
// Round-robin arbiter sharing one burst-capable memory port among NPORTS masters,
// locking the port for write bursts and steering read returns via an order FIFO.
module mem_port_arb #(
  parameter int NPORTS          = 3,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int BURSTLEN_WIDTH  = 3,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic           clock,
  input logic           reset,
  mem_port_arb_if.slave bus
);
  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int FW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic {IDLE, WBURST} state_t;

  state_t                    state, state_next;
  logic [PW-1:0]             rr_ptr, rr_next;
  logic [PW-1:0]             owner, owner_next;
  logic [BURSTLEN_WIDTH-1:0] wbeats, wbeats_next;
  logic [PW-1:0]             winner;
  logic                      has_winner;
  logic [NPORTS-1:0]         eligible;
  logic [BURSTLEN_WIDTH-1:0] sel_burst_len;
  logic                      rd_go, wr_go;
  logic                      push, pop;

  logic [PW-1:0]             fifo_port [MAX_OUTSTANDING];
  logic [BURSTLEN_WIDTH-1:0] fifo_len  [MAX_OUTSTANDING];
  logic [FW-1:0]             wr_idx, rd_idx;
  logic [FW:0]               count;
  logic [BURSTLEN_WIDTH-1:0] beat_cnt;
  logic                      fifo_full, fifo_empty;
  logic [PW-1:0]             head_port;

  function automatic logic [PW-1:0] next_port(input logic [PW-1:0] p);
    return (int'(p) == NPORTS - 1) ? '0 : p + PW'(1);
  endfunction

  assign fifo_full  = (count == (FW+1)'(MAX_OUTSTANDING));
  assign fifo_empty = (count == '0);
  assign head_port  = fifo_port[rd_idx];

  // Fullness gates eligibility so that read returns never feed the grant path.
  always_comb begin
    has_winner = 1'b0;
    winner     = '0;
    eligible   = bus.c_wr | (bus.c_rd & {NPORTS{!fifo_full}});
    if (state == WBURST) begin
      has_winner = 1'b1;
      winner     = owner;
    end else begin
      for (int k = 0; k < NPORTS; k++) begin
        if (!has_winner && eligible[(int'(rr_ptr) + k) % NPORTS]) begin
          has_winner = 1'b1;
          winner     = PW'((int'(rr_ptr) + k) % NPORTS);
        end
      end
    end
  end

  always_comb begin
    state_next        = state;
    rr_next           = rr_ptr;
    owner_next        = owner;
    wbeats_next       = wbeats;
    push              = 1'b0;
    rd_go             = 1'b0;
    wr_go             = 1'b0;
    sel_burst_len     = bus.c_burst_len[int'(winner)*BURSTLEN_WIDTH +: BURSTLEN_WIDTH];
    bus.mm_addr       = bus.c_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
    bus.mm_burst_len  = sel_burst_len;
    bus.mm_data_out   = bus.c_data_in[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
    bus.c_waitrequest = '1;
    if (has_winner) begin
      bus.c_waitrequest[winner] = bus.mm_waitrequest;
      wr_go = bus.c_wr[winner];
      rd_go = (state == IDLE) && bus.c_rd[winner] && !bus.c_wr[winner];
    end
    bus.mm_wr = wr_go;
    bus.mm_rd = rd_go;
    case (state)
      IDLE: begin
        if (rd_go && !bus.mm_waitrequest) begin
          push    = 1'b1;
          rr_next = next_port(winner);
        end else if (wr_go && !bus.mm_waitrequest) begin
          if (sel_burst_len == '0) begin
            rr_next = next_port(winner);
          end else begin
            owner_next  = winner;
            wbeats_next = sel_burst_len;
            state_next  = WBURST;
          end
        end
      end
      WBURST: begin
        if (wr_go && !bus.mm_waitrequest) begin
          wbeats_next = wbeats - BURSTLEN_WIDTH'(1);
          if (wbeats == BURSTLEN_WIDTH'(1)) begin
            state_next = IDLE;
            rr_next    = next_port(owner);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      wbeats <= '0;
    end else begin
      state  <= state_next;
      rr_ptr <= rr_next;
      owner  <= owner_next;
      wbeats <= wbeats_next;
    end
  end

  // Beats arriving with nothing outstanding are dropped and flagged as stray.
  always_comb begin
    bus.c_data_out     = bus.mm_data_in;
    bus.c_rd_valid     = '0;
    bus.stray_rd_valid = 1'b0;
    pop                = 1'b0;
    if (bus.mm_rd_valid) begin
      if (fifo_empty) begin
        bus.stray_rd_valid = 1'b1;
      end else begin
        bus.c_rd_valid[head_port] = 1'b1;
        pop = (beat_cnt == fifo_len[rd_idx]);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_port[wr_idx] <= winner;
      fifo_len[wr_idx]  <= sel_burst_len;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_idx   <= '0;
      rd_idx   <= '0;
      count    <= '0;
      beat_cnt <= '0;
    end else begin
      if (push) wr_idx <= wr_idx + FW'(1);
      if (pop) begin
        rd_idx   <= rd_idx + FW'(1);
        beat_cnt <= '0;
      end else if (bus.mm_rd_valid && !fifo_empty) begin
        beat_cnt <= beat_cnt + BURSTLEN_WIDTH'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (FW+1)'(1);
        2'b01:   count <= count - (FW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb: contention, write lock, return routing,
// backpressure and reset mid-operation, with hand-computed expectations.
module tb_mem_port_arb;
  localparam int NP = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 3;

  logic clock;
  logic reset;
  int   assert_count;
  int   fail_count;

  mem_port_arb_if #(.NPORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURSTLEN_WIDTH(BW)) bus ();

  mem_port_arb #(
    .NPORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .BURSTLEN_WIDTH(BW), .MAX_OUTSTANDING(4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] rd, input logic [2:0] wr,
                               input logic [BW-1:0] bl0, input logic [BW-1:0] bl1,
                               input logic [BW-1:0] bl2);
    bus.c_rd        = rd;
    bus.c_wr        = wr;
    bus.c_burst_len = {bl2, bl1, bl0};
    #1;
  endtask

  task automatic stepClock();
    @(posedge clock);
    #1;
  endtask

  task automatic checkGrant(input string tag, input logic rd, input logic wr, input logic [2:0] wait_req);
    checkOutput({tag, "_mm_rd"}, 64'(bus.mm_rd), 64'(rd));
    checkOutput({tag, "_mm_wr"}, 64'(bus.mm_wr), 64'(wr));
    checkOutput({tag, "_wait"}, 64'(bus.c_waitrequest), 64'(wait_req));
  endtask

  task automatic checkReturn(input string tag, input logic [2:0] valid, input logic stray);
    checkOutput({tag, "_rd_valid"}, 64'(bus.c_rd_valid), 64'(valid));
    checkOutput({tag, "_stray"}, 64'(bus.stray_rd_valid), 64'(stray));
  endtask

  task automatic drainBeat(input string tag, input logic [2:0] valid, input logic stray);
    bus.mm_rd_valid = 1'b1;
    #1;
    checkReturn(tag, valid, stray);
    stepClock();
    bus.mm_rd_valid = 1'b0;
  endtask

  initial begin
    logic [2:0] drain_exp [4];
    assert_count       = 0;
    fail_count         = 0;
    reset              = 1'b1;
    bus.c_addr         = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
    bus.c_data_in      = {32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
    bus.c_rd           = '0;
    bus.c_wr           = '0;
    bus.c_burst_len    = '0;
    bus.mm_data_in     = '0;
    bus.mm_waitrequest = 1'b0;
    bus.mm_rd_valid    = 1'b0;
    stepClock();
    stepClock();
    checkGrant("reset", 1'b0, 1'b0, 3'b111);
    checkReturn("reset", 3'b000, 1'b0);
    reset = 1'b0;

    $display("[TB] contention");
    applyStimulus(3'b111, 3'b000, 0, 0, 0);
    checkGrant("cont0", 1'b1, 1'b0, 3'b110);
    checkOutput("cont0_addr", 64'(bus.mm_addr), 64'h1000);
    stepClock();
    checkGrant("cont1", 1'b1, 1'b0, 3'b101);
    checkOutput("cont1_addr", 64'(bus.mm_addr), 64'h2000);
    stepClock();
    checkGrant("cont2", 1'b1, 1'b0, 3'b011);
    stepClock();
    checkGrant("cont3", 1'b1, 1'b0, 3'b110);
    stepClock();
    checkGrant("cont_full", 1'b0, 1'b0, 3'b111);
    bus.mm_rd_valid = 1'b1;
    bus.mm_data_in  = 32'h0000_00A0;
    #1;
    checkReturn("cont_ret0", 3'b001, 1'b0);
    checkOutput("cont_ret0_data", 64'(bus.c_data_out), 64'h00A0);
    checkGrant("cont_full_pop", 1'b0, 1'b0, 3'b111);
    stepClock();
    checkGrant("cont4", 1'b1, 1'b0, 3'b101);
    checkReturn("cont_ret1", 3'b010, 1'b0);
    stepClock();
    bus.mm_rd_valid = 1'b0;
    #1;
    checkGrant("cont5", 1'b1, 1'b0, 3'b011);
    stepClock();
    applyStimulus(3'b000, 3'b000, 0, 0, 0);
    drain_exp = '{3'b100, 3'b001, 3'b010, 3'b100};
    for (int i = 0; i < 4; i++) drainBeat($sformatf("cont_drain%0d", i), drain_exp[i], 1'b0);
    drainBeat("cont_stray", 3'b000, 1'b1);

    $display("[TB] write lock");
    applyStimulus(3'b000, 3'b001, 0, 0, 0);
    checkGrant("wsingle", 1'b0, 1'b1, 3'b110);
    checkOutput("wsingle_data", 64'(bus.mm_data_out), 64'hD000_0000);
    stepClock();
    applyStimulus(3'b101, 3'b010, 0, 3, 0);
    checkGrant("wl_b0", 1'b0, 1'b1, 3'b101);
    checkOutput("wl_b0_len", 64'(bus.mm_burst_len), 64'd3);
    checkOutput("wl_b0_addr", 64'(bus.mm_addr), 64'h2000);
    stepClock();
    checkGrant("wl_b1", 1'b0, 1'b1, 3'b101);
    stepClock();
    applyStimulus(3'b101, 3'b000, 0, 3, 0);
    checkGrant("wl_hold0", 1'b0, 1'b0, 3'b101);
    stepClock();
    checkGrant("wl_hold1", 1'b0, 1'b0, 3'b101);
    stepClock();
    applyStimulus(3'b101, 3'b010, 0, 3, 0);
    checkGrant("wl_b2", 1'b0, 1'b1, 3'b101);
    stepClock();
    checkGrant("wl_b3", 1'b0, 1'b1, 3'b101);
    stepClock();
    applyStimulus(3'b101, 3'b000, 0, 0, 0);
    checkGrant("wl_p2", 1'b1, 1'b0, 3'b011);
    stepClock();
    checkGrant("wl_p0", 1'b1, 1'b0, 3'b110);
    stepClock();
    applyStimulus(3'b000, 3'b000, 0, 0, 0);
    drainBeat("wl_ret_p2", 3'b100, 1'b0);
    drainBeat("wl_ret_p0", 3'b001, 1'b0);

    $display("[TB] return routing");
    applyStimulus(3'b100, 3'b000, 0, 0, 3);
    checkGrant("rt_p2", 1'b1, 1'b0, 3'b011);
    checkOutput("rt_p2_len", 64'(bus.mm_burst_len), 64'd3);
    stepClock();
    applyStimulus(3'b001, 3'b000, 1, 0, 0);
    checkGrant("rt_p0", 1'b1, 1'b0, 3'b110);
    stepClock();
    applyStimulus(3'b000, 3'b000, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      bus.mm_data_in = 32'h0000_00B0 + 32'(i);
      #1;
      checkOutput($sformatf("rt_data%0d", i), 64'(bus.c_data_out), 64'h00B0 + 64'(i));
      drainBeat($sformatf("rt_beat%0d", i), (i < 4) ? 3'b100 : 3'b001, 1'b0);
    end
    drainBeat("rt_stray", 3'b000, 1'b1);

    $display("[TB] backpressure");
    bus.mm_waitrequest = 1'b1;
    applyStimulus(3'b110, 3'b000, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      checkGrant($sformatf("bp_wait%0d", i), 1'b1, 1'b0, 3'b111);
      checkOutput($sformatf("bp_addr%0d", i), 64'(bus.mm_addr), 64'h2000);
      stepClock();
    end
    bus.mm_waitrequest = 1'b0;
    #1;
    checkGrant("bp_accept", 1'b1, 1'b0, 3'b101);
    stepClock();
    applyStimulus(3'b000, 3'b000, 0, 0, 0);
    drainBeat("bp_ret", 3'b010, 1'b0);
    drainBeat("bp_stray", 3'b000, 1'b1);

    $display("[TB] reset mid-operation");
    applyStimulus(3'b100, 3'b000, 0, 0, 1);
    stepClock();
    applyStimulus(3'b001, 3'b000, 0, 0, 0);
    stepClock();
    applyStimulus(3'b000, 3'b010, 0, 3, 0);
    checkGrant("rst_w", 1'b0, 1'b1, 3'b101);
    stepClock();
    applyStimulus(3'b000, 3'b000, 0, 0, 0);
    reset = 1'b1;
    stepClock();
    reset = 1'b0;
    applyStimulus(3'b001, 3'b000, 0, 0, 0);
    checkGrant("rst_idle", 1'b1, 1'b0, 3'b110);
    applyStimulus(3'b000, 3'b000, 0, 0, 0);
    for (int i = 0; i < 3; i++) drainBeat($sformatf("rst_stray%0d", i), 3'b000, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end
endmodule
